// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the board-input debouncer.
// Counter widths never collapse to zero bits.
package debounce_pkg;

    localparam int DEFAULT_CLK_DIV      = 50000;
    localparam int DEFAULT_STABLE_TICKS = 10;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input bit: optional inversion, 2-flop sync,
// tick-driven stability counter and registered edge strobes.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic invert,
    input  logic tick,
    output logic debounced,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2_min1(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            debounced <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync1 <= raw ^ invert;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            // Any sample matching the current level restarts the count.
            if (sync2 == debounced) begin
                cnt <= '0;
            end else if (tick && cnt == LAST) begin
                debounced <= sync2;
                cnt       <= '0;
                rise      <= sync2;
                fall      <= ~sync2;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_debouncer_16.sv
// Debounces WIDTH board inputs for the PIO in_port using a shared
// prescaled tick and one debounce_channel per bit.
module input_debouncer_16
    import debounce_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               CLK_DIV      = DEFAULT_CLK_DIV,
    parameter int               STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter logic [WIDTH-1:0] INVERT_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             tick
);

    localparam int PW = clog2_min1(CLK_DIV);
    localparam logic [PW-1:0] PLAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre  <= '0;
            tick <= 1'b0;
        end else if (pre == PLAST) begin
            pre  <= '0;
            tick <= 1'b1;
        end else begin
            pre  <= pre + 1'b1;
            tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw      (raw_in[i]),
            .invert   (INVERT_MASK[i]),
            .tick     (tick),
            .debounced(debounced_out[i]),
            .rise     (rise_pulse[i]),
            .fall     (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer_16.sv
// Directed bench for input_debouncer_16: three builds share clk/reset.
// A: CLK_DIV=4 ST=3, B: same with bit 0 inverted, C: CLK_DIV=1 ST=1.
module tb_input_debouncer_16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] raw_a, raw_b, raw_c;
    logic [15:0] out_a, out_b, out_c;
    logic [15:0] rise_a, rise_b, rise_c;
    logic [15:0] fall_a, fall_b, fall_c;
    logic        tick_a, tick_b, tick_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    input_debouncer_16 #(
        .WIDTH(16), .CLK_DIV(4), .STABLE_TICKS(3),
        .INVERT_MASK(16'h0000)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_a),
        .debounced_out(out_a), .rise_pulse(rise_a),
        .fall_pulse(fall_a), .tick(tick_a)
    );

    input_debouncer_16 #(
        .WIDTH(16), .CLK_DIV(4), .STABLE_TICKS(3),
        .INVERT_MASK(16'h0001)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_b),
        .debounced_out(out_b), .rise_pulse(rise_b),
        .fall_pulse(fall_b), .tick(tick_b)
    );

    input_debouncer_16 #(
        .WIDTH(16), .CLK_DIV(1), .STABLE_TICKS(1),
        .INVERT_MASK(16'h0000)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_c),
        .debounced_out(out_c), .rise_pulse(rise_c),
        .fall_pulse(fall_c), .tick(tick_c)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Park on a negedge where tick is high so latency is exact.
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        while (tick_a !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, tick_a}, 32'd1);
    endtask

    task automatic watch(input int sel, input int b, input logic target,
                         output int first, output int rises,
                         output int falls, output logic pulse_first);
        logic o, r, f;
        first = -1;
        rises = 0;
        falls = 0;
        pulse_first = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            o = (sel == 0) ? out_a[b]  : out_b[b];
            r = (sel == 0) ? rise_a[b] : rise_b[b];
            f = (sel == 0) ? fall_a[b] : fall_b[b];
            if (r) rises++;
            if (f) falls++;
            if (first < 0 && o === target) begin
                first = n;
                pulse_first = target ? r : f;
            end
        end
    endtask

    int   first, rises, falls, bounce_bad, partial, pulses;
    logic pf;
    logic [15:0] rise_at;

    initial begin
        // 1: reset with all pads high
        reset_n = 1'b0;
        raw_a = 16'hFFFF;
        raw_b = 16'h0001;
        raw_c = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_out", {16'h0, out_a}, 32'h0);
        check("rst_rise", {16'h0, rise_a}, 32'h0);
        check("rst_fall", {16'h0, fall_a}, 32'h0);
        check("rst_tick", {31'b0, tick_a}, 32'h0);
        check("rst_tick_c", {31'b0, tick_c}, 32'h0);
        raw_a = 16'h0000;
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("tick_k%0d", k), {31'b0, tick_a},
                  (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        check("tick_b_eq", {31'b0, tick_b}, {31'b0, tick_a});
        check("tick_c_hi", {31'b0, tick_c}, 32'd1);
        check("inv_idle", {16'h0, out_b}, 32'h0);

        // 2: clean step on bit 0
        wait_tick("wt_step");
        raw_a[0] = 1'b1;
        watch(0, 0, 1'b1, first, rises, falls, pf);
        check("step_lat", first, 32'd13);
        check("step_rise_n", rises, 32'd1);
        check("step_fall_n", falls, 32'd0);
        check("step_pulse", {31'b0, pf}, 32'd1);
        check("step_out", {16'h0, out_a}, 32'h0001);

        // 3: bounce on bit 3
        bounce_bad = 0;
        for (int t = 0; t < 4; t++) begin
            raw_a[3] = (t % 2 == 0);
            repeat (6) begin
                @(negedge clk);
                if (out_a !== 16'h0001 || rise_a !== 16'h0) bounce_bad++;
            end
        end
        check("bounce_quiet", bounce_bad, 32'd0);
        wait_tick("wt_bounce");
        raw_a[3] = 1'b1;
        watch(0, 3, 1'b1, first, rises, falls, pf);
        check("bounce_lat", first, 32'd13);
        check("bounce_rise_n", rises, 32'd1);
        check("bounce_out", {16'h0, out_a}, 32'h0009);

        // 4: inverted bit 0 on build B
        wait_tick("wt_inv");
        raw_b[0] = 1'b0;
        watch(1, 0, 1'b1, first, rises, falls, pf);
        check("inv_rise_lat", first, 32'd13);
        check("inv_rise_n", rises, 32'd1);
        check("inv_rise_pf", {31'b0, pf}, 32'd1);
        wait_tick("wt_inv2");
        raw_b[0] = 1'b1;
        watch(1, 0, 1'b0, first, rises, falls, pf);
        check("inv_fall_lat", first, 32'd13);
        check("inv_fall_n", falls, 32'd1);
        check("inv_fall_rise", rises, 32'd0);
        check("inv_out", {16'h0, out_b}, 32'h0);

        // 6a: reset mid-count clears outputs asynchronously
        raw_a = 16'h0000;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out", {16'h0, out_a}, 32'h0);
        check("mid_rst_tick", {31'b0, tick_a}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 6b: CLK_DIV=1, STABLE_TICKS=1 build
        @(negedge clk);
        raw_c[5] = 1'b1;
        @(negedge clk);
        check("c_n1", {16'h0, out_c}, 32'h0);
        @(negedge clk);
        check("c_n2", {16'h0, out_c}, 32'h0);
        @(negedge clk);
        check("c_n3", {16'h0, out_c}, 32'h0020);
        check("c_rise", {16'h0, rise_c}, 32'h0020);
        check("c_fall", {16'h0, fall_c}, 32'h0);

        // 5: simultaneous rise of several bits
        wait_tick("wt_multi");
        raw_a = 16'hA5A5;
        first = -1;
        partial = 0;
        pulses = 0;
        rise_at = 16'h0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_a !== 16'h0 && out_a !== 16'hA5A5) partial++;
            if (rise_a !== 16'h0) pulses++;
            if (first < 0 && out_a === 16'hA5A5) begin
                first = n;
                rise_at = rise_a;
            end
        end
        check("multi_lat", first, 32'd13);
        check("multi_partial", partial, 32'd0);
        check("multi_rise", {16'h0, rise_at}, 32'h0000A5A5);
        check("multi_pulses", pulses, 32'd1);
        check("multi_fall", {16'h0, fall_a}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
